// File: rtl/ssp_fifo_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ssp_fifo_if : push/pop handshake and status bundle for ssp_fifo           |
// | Rev 1.0 -- initial release                                               |
// +--------------------------------------------------------------------------+
interface ssp_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int c_CW = $clog2(DEPTH) + 1;

  logic             WR_EN;
  logic [WIDTH-1:0] WR_DATA;
  logic             RD_EN;
  logic             ERR_CLR;
  logic [WIDTH-1:0] RD_DATA;
  logic             FULL;
  logic             EMPTY;
  logic [c_CW-1:0]  COUNT;
  logic             INTR;
  logic             OVERFLOW;
  logic             UNDERFLOW;

  modport master (
    output WR_EN, WR_DATA, RD_EN, ERR_CLR,
    input  RD_DATA, FULL, EMPTY, COUNT, INTR, OVERFLOW, UNDERFLOW
  );

  modport slave (
    input  WR_EN, WR_DATA, RD_EN, ERR_CLR,
    output RD_DATA, FULL, EMPTY, COUNT, INTR, OVERFLOW, UNDERFLOW
  );
endinterface
`default_nettype wire

// File: rtl/ssp_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ssp_fifo : first-word fall-through circular FIFO with sticky error flags |
// | Rev 1.0 -- initial release                                               |
// +--------------------------------------------------------------------------+
module ssp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  wire logic   PCLK,
  input  wire logic   CLEAR_B,
  ssp_fifo_if.slave   bus
);
  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_CW-1:0]  r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == c_CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = bus.RD_EN && !w_empty;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign w_push  = bus.WR_EN && (!w_full || w_pop);

  always_ff @(posedge PCLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.WR_DATA;
    end
  end

  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
      // A fresh error wins over a simultaneous clear.
      r_overflow  <= (r_overflow  && !bus.ERR_CLR) || (bus.WR_EN && !w_push);
      r_underflow <= (r_underflow && !bus.ERR_CLR) || (bus.RD_EN && !w_pop);
    end
  end

  assign bus.RD_DATA   = w_empty ? '0 : r_mem[r_rd_ptr];
  assign bus.FULL      = w_full;
  assign bus.EMPTY     = w_empty;
  assign bus.COUNT     = r_count;
  assign bus.INTR      = w_full;
  assign bus.OVERFLOW  = r_overflow;
  assign bus.UNDERFLOW = r_underflow;
endmodule
`default_nettype wire
